// File: rtl/hqm_aw_cdc_hs_rx.sv
// hqm_aw_cdc_hs_rx
// Receive side of a 4-phase req/ack handshake. The request level arrives
// already double-synchronized into clk. The sender's quasi-static data bus is
// captured once per transfer and offered locally with valid/ready. A registered
// ack level goes back to the sender, and completed transfers are counted.
//
// Optional build macro: HQM_AW_CDC_HS_RX_ERRCHK_EN
//   When defined, a sticky err flag reports two sender protocol violations
//   seen while data is being offered locally:
//     - the request is withdrawn early;
//     - the data bus changes early.
//   When the macro is undefined, err is tied low and no compare logic exists.
//
// All outputs are driven directly from registers.

module hqm_aw_cdc_hs_rx #(
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_sync,
    input  logic [DWIDTH-1:0] data_async,
    output logic              ack,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    input  logic              out_ready,
    output logic [CWIDTH-1:0] xfer_cnt,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_VALID = 2'b01,
        ST_ACK   = 2'b10
    } state_t;

    state_t              state_r;
    logic                ack_r;
    logic                out_valid_r;
    logic [DWIDTH-1:0]   out_data_r;
    logic [CWIDTH-1:0]   xfer_cnt_r;

    // Handshake FSM: capture on request, offer locally, acknowledge, wait for release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ack_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {DWIDTH{1'b0}};
            xfer_cnt_r  <= {CWIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Level-sensitive: a request that is high here starts a
                    // transfer. This is the only place data_async is sampled.
                    if (req_sync) begin
                        out_data_r  <= data_async;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_VALID;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_VALID: begin
                    // Hold data/valid stable until the consumer takes it.
                    // Accept even if the request has already dropped; ACK
                    // then exits on the next cycle.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        ack_r       <= 1'b1;
                        xfer_cnt_r  <= xfer_cnt_r + CWIDTH'(1);
                        state_r     <= ST_ACK;
                    end else begin
                        state_r     <= ST_VALID;
                    end
                end
                ST_ACK: begin
                    // Keep ack high until the sender releases its request.
                    if (!req_sync) begin
                        ack_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ACK;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ack_r       <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ack       = ack_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign xfer_cnt  = xfer_cnt_r;

`ifdef HQM_AW_CDC_HS_RX_ERRCHK_EN
    // Returns 1 when the captured word no longer matches the live sender bus.
    function automatic logic data_moved(input logic [DWIDTH-1:0] held,
                                        input logic [DWIDTH-1:0] live);
        data_moved = |(held ^ live);
    endfunction

    logic err_r;

    // Sticky protocol-error flag, checked on every cycle spent offering data.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_VALID) &&
                     (!req_sync || data_moved(out_data_r, data_async))) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hqm_aw_cdc_hs_rx.sv
// Directed bench for hqm_aw_cdc_hs_rx (DWIDTH=32, CWIDTH=4 so the counter wrap
// is reachable). A rule-level model predicts every output each cycle; literal
// checks at known points pin the model against hand-computed values.

module tb_hqm_aw_cdc_hs_rx;

`ifdef HQM_AW_CDC_HS_RX_ERRCHK_EN
    localparam logic ERRCHK = 1'b1;
`else
    localparam logic ERRCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_sync;
    logic [31:0] data_async;
    logic        ack;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [3:0]  xfer_cnt;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    logic chk_on = 1'b0;

    logic [31:0] rcvq[$];

    // Model state: the observable outputs predicted from the behaviour rules.
    logic        m_ack, m_valid, m_err;
    logic [31:0] m_data;
    logic [3:0]  m_cnt;

    hqm_aw_cdc_hs_rx #(.DWIDTH(32), .CWIDTH(4)) dut (
        .clk(clk), .rst(rst), .req_sync(req_sync), .data_async(data_async),
        .ack(ack), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .xfer_cnt(xfer_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: idle means neither valid nor ack; capture, accept and release
    // follow the transfer rules directly.
    always @(posedge clk) begin
        if (rst) begin
            m_ack <= 1'b0; m_valid <= 1'b0; m_data <= 32'h0; m_cnt <= 4'd0; m_err <= 1'b0;
        end else begin
            if (!m_ack && !m_valid && req_sync) begin
                m_valid <= 1'b1;
                m_data  <= data_async;
            end
            if (m_valid && out_ready) begin
                m_valid <= 1'b0;
                m_ack   <= 1'b1;
                m_cnt   <= m_cnt + 4'd1;
            end
            if (m_ack && !req_sync) m_ack <= 1'b0;
            if (ERRCHK && m_valid && (!req_sync || (m_data != data_async))) m_err <= 1'b1;
        end
    end

    // Compare process: every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_on) begin
            check("ack", {63'd0, ack}, {63'd0, m_ack});
            check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
            check("out_data", {32'd0, out_data}, {32'd0, m_data});
            check("xfer_cnt", {60'd0, xfer_cnt}, {60'd0, m_cnt});
            check("err", {63'd0, err}, {63'd0, m_err});
        end
    end

    // Record accepted words (accept happens at the following posedge).
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) rcvq.push_back(out_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic val);
        int k = 0;
        while (ack !== val && k < 20) begin
            tick();
            k++;
        end
        check("ack_wait", {63'd0, ack}, {63'd0, val});
    endtask

    task automatic send(input logic [31:0] d);
        data_async = d;
        req_sync   = 1'b1;
        wait_ack(1'b1);
        req_sync   = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; req_sync = 1'b0; data_async = 32'h0; out_ready = 1'b0;
        tick(); tick();
        chk_on = 1'b1;
        check("rst_ack", {63'd0, ack}, 64'd0);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_data", {32'd0, out_data}, 64'd0);
        check("rst_cnt", {60'd0, xfer_cnt}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        rst = 1'b0;
        tick(); tick(); tick();

        // Single transfer.
        req_sync = 1'b1; data_async = 32'hDEADBEEF; out_ready = 1'b1;
        tick();
        check("t1_valid", {63'd0, out_valid}, 64'd1);
        check("t1_data", {32'd0, out_data}, 64'hDEADBEEF);
        tick();
        check("t1_ack", {63'd0, ack}, 64'd1);
        check("t1_cnt", {60'd0, xfer_cnt}, 64'd1);
        tick(); tick();
        check("t1_ack_hold", {63'd0, ack}, 64'd1);
        req_sync = 1'b0;
        tick();
        check("t1_ack_fall", {63'd0, ack}, 64'd0);

        // Backpressure.
        out_ready = 1'b0; req_sync = 1'b1; data_async = 32'hA5A55A5A;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_data", {32'd0, out_data}, 64'hA5A55A5A);
            check("bp_ack", {63'd0, ack}, 64'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_ack_rise", {63'd0, ack}, 64'd1);
        check("bp_cnt", {60'd0, xfer_cnt}, 64'd2);
        req_sync = 1'b0;
        tick();

        // Back-to-back transfers.
        do_reset();
        rcvq.delete();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(32'(i));
        check("b2b_count", 64'(rcvq.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rcvq.size()) check("b2b_word", {32'd0, rcvq[i]}, 64'(i + 1));
        end
        check("b2b_cnt", {60'd0, xfer_cnt}, 64'd4);

        // Counter wrap with a 4-bit counter.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            send(32'h100 + 32'(i));
            if (i == 15) check("wrap_15", {60'd0, xfer_cnt}, 64'd15);
            if (i == 16) check("wrap_0", {60'd0, xfer_cnt}, 64'd0);
            if (i == 17) check("wrap_1", {60'd0, xfer_cnt}, 64'd1);
        end

        // Reset while in ACK with the request still high.
        do_reset();
        req_sync = 1'b1; data_async = 32'h77; out_ready = 1'b1;
        tick(); tick();
        check("mr_ack_pre", {63'd0, ack}, 64'd1);
        rst = 1'b1;
        tick();
        check("mr_ack", {63'd0, ack}, 64'd0);
        check("mr_valid", {63'd0, out_valid}, 64'd0);
        check("mr_cnt", {60'd0, xfer_cnt}, 64'd0);
        rst = 1'b0;
        tick();
        check("mr_recap_valid", {63'd0, out_valid}, 64'd1);
        check("mr_recap_data", {32'd0, out_data}, 64'h77);
        tick();
        req_sync = 1'b0;
        tick();

        // Request withdrawn while data is offered.
        out_ready = 1'b0; req_sync = 1'b1; data_async = 32'h99;
        tick();
        req_sync = 1'b0;
        tick();
        check("er_err", {63'd0, err}, {63'd0, ERRCHK});
        check("er_valid_hold", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        tick();
        check("er_ack", {63'd0, ack}, 64'd1);
        tick();
        check("er_ack_exit", {63'd0, ack}, 64'd0);
        send(32'h1234);
        check("er_sticky", {63'd0, err}, {63'd0, ERRCHK});
        do_reset();
        check("er_cleared", {63'd0, err}, 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
